sw4_debounce_unit: RTL and testbench
====================================

// Module: sw4_debounce_unit
// PURPOSE
//   Debounces the SW4 push-button and converts each clean press into a toggle
//   of size_flag, a mode/size select for the downstream game logic.
//   Presses change size_flag only while the game is idle (run_flag=0).
//   rtg_btn (return-to-game) clears the selection.
//   Sits between the board button pin and the game controller.
// PARAMETERS
//   CNT_W     16  width of the stability counter; debounce window = 2**CNT_W clk
//                 (65536 cycles = 655.36 us at 100 MHz)
// PORTS
//   clk        in   1  system clock, 100 MHz, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   btn        in   1  raw SW4 level, may bounce, 1 = pressed
//   run_flag   in   1  1 = game running; presses are ignored
//   rtg_btn    in   1  synchronous clear of size_flag; must be high >= 1 clk
//   size_flag  out  1  registered toggle state
// BEHAVIOUR
//   - Reset (rst_n=0, async):
//     - btn_db=0, counter=0, size_flag=0.
//     - Synchronizer flops are 0.
//   - Sampled input btn_s:
//     - btn directly, or the synchronizer output (see CONFIGURATION).
//   - Stability counter (CNT_W bits):
//     - If btn_s == btn_db: counter <= 0.
//     - Else, if counter == 2**CNT_W-1: btn_db <= btn_s and counter <= 0 (commit).
//     - Else: counter <= counter+1.
//     - A commit therefore needs 2**CNT_W consecutive mismatching samples.
//     - Any single-cycle return to btn_db restarts the count.
//     - The counter never wraps.
//   - press event:
//     - Single-cycle internal pulse on the commit edge where btn_db goes 0->1.
//     - Releases (1->0) are debounced identically but generate no event.
//   - size_flag update, priority high -> low:
//     1. rtg_btn=1 -> size_flag <= 0 (wins over a simultaneous press)
//     2. press & run_flag=0 -> size_flag <= ~size_flag
//     3. otherwise hold
//   - Latency: size_flag toggles on the same clock edge that commits btn_db=1.
//     That is 2**CNT_W cycles after the first stable-high sample (+2 with sync).
//   - run_flag is sampled only on the commit edge:
//     - A press committed while run_flag=1 is discarded.
//     - The press is not queued and not replayed when run_flag falls.
//     - btn_db still tracks the button.
//   - Holding the button generates exactly one press.
//     A new press requires a debounced release first.
//   - Reset mid-count discards the partial count and any pending press.
// CONFIGURATION
//   BTN_SYNC_EN defined:
//     - btn passes through a 2-flop synchronizer (reset 0) before the counter.
//     - Adds 2 cycles of latency.
//   BTN_SYNC_EN undefined:
//     - btn_s = btn, no added latency.
//     - The board must deliver btn synchronous to clk.
// TESTING  (CNT_W=16, clk 10 ns)
//   - Bounce: btn toggles every 8621 cycles, 7 times.
//     -> btn_db stays 0, size_flag stays 0.
//   - Clean press: btn=1 held 131072 cycles after the bounce.
//     -> size_flag 0->1 exactly 65536 cycles after the last rising edge (+2 if BTN_SYNC_EN).
//     -> Single toggle only.
//   - Bouncy release, then second clean press.
//     -> No toggle on release; second press sets size_flag 1->0.
//   - run_flag=1, bounce plus 131072-cycle press.
//     -> size_flag unchanged; btn_db reaches 1.
//   - Clear: rtg_btn 1-cycle pulse with size_flag=1 -> size_flag=0 next edge.
//     - rtg_btn on the same edge as a press commit -> size_flag=0.
//   - Reset: assert rst_n=0 at counter=40000, btn held high.
//     -> All state 0 immediately.
//     -> After release, a full 65536-cycle window is required before the toggle.

Source files
------------

// File: rtl/sw4_debounce_unit.sv
// SW4 debouncer: a stability counter commits the button level, and each committed press toggles
// size_flag_o while the game is idle. Optional macro BTN_SYNC_EN adds a 2-flop input synchronizer.
module sw4_debounce_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic run_flag_i,
  input  logic rtg_btn_i,
  output logic size_flag_o
);

  logic             btn_s;
  logic             btn_db_q, btn_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             size_flag_q, size_flag_d;
  logic             press;

`ifdef BTN_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign btn_s = sync_q[1];
`else
  assign btn_s = btn_i;
`endif

  // Commit only after 2**CNT_W consecutive samples that differ from the debounced level.
  always_comb begin
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    press    = 1'b0;
    if (btn_s == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      btn_db_d = btn_s;
      cnt_d    = '0;
      press    = btn_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Clear beats a simultaneous press; presses during a run are dropped, not queued.
  always_comb begin
    size_flag_d = size_flag_q;
    if (rtg_btn_i) begin
      size_flag_d = 1'b0;
    end else if (press && !run_flag_i) begin
      size_flag_d = ~size_flag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q    <= 1'b0;
      cnt_q       <= '0;
      size_flag_q <= 1'b0;
    end else begin
      btn_db_q    <= btn_db_d;
      cnt_q       <= cnt_d;
      size_flag_q <= size_flag_d;
    end
  end

  assign size_flag_o = size_flag_q;

endmodule

// File: tb/tb_sw4_debounce_unit.sv
// Bench for sw4_debounce_unit with a shortened debounce window; expected size_flag toggles
// (edge number and value) are queued when stimulus is driven and matched by a monitor.
module tb_sw4_debounce_unit;

  localparam int unsigned CntW = 6;
  localparam int Win = 1 << CntW;
`ifdef BTN_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic run_flag = 1'b0;
  logic rtg_btn = 1'b0;
  logic size_flag;

  sw4_debounce_unit #(
    .CNT_W(CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (btn),
    .run_flag_i (run_flag),
    .rtg_btn_i  (rtg_btn),
    .size_flag_o(size_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int edge_n;
    int val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_bad = 0;
  logic prev_flag = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every change of size_flag outside reset must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (size_flag !== prev_flag)) begin
      if (sb.size() == 0) begin
        check_val("unexpected_toggle", cyc, -1);
      end else begin
        mon_e = sb.pop_front();
        check_val("toggle_edge", cyc, mon_e.edge_n);
        check_val("toggle_value", int'(size_flag), mon_e.val);
      end
    end
    prev_flag <= size_flag;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Seven level changes 8 cycles apart, ending at final_v; returns the edge of the last change.
  task automatic bouncy_edge(input logic final_v, output int edge_n);
    for (int i = 0; i < 7; i++) begin
      btn    = (i % 2 == 0) ? final_v : ~final_v;
      edge_n = cyc + 1;
      if (i < 6) step(8);
    end
  endtask

  task automatic expect_toggle(input int first_edge, input int val);
    exp_t e;
    e.edge_n = first_edge + Win - 1 + SyncLat;
    e.val    = val;
    sb.push_back(e);
  endtask

  int e;
  int commit_edge;
  exp_t rtg_e;

  initial begin
    step(3);
    check_val("rst_flag", int'(size_flag), 0);
    check_val("rst_db", int'(dut.btn_db_q), 0);
    check_val("rst_cnt", int'(dut.cnt_q), 0);
    rst_n = 1'b1;
    step(4);

    // Bounce then clean press: one toggle 0->1.
    bouncy_edge(1'b1, e);
    check_val("bounce_db", int'(dut.btn_db_q), 0);
    check_val("bounce_flag", int'(size_flag), 0);
    expect_toggle(e, 1);
    step(2 * Win);
    check_val("press1_flag", int'(size_flag), 1);

    // Bouncy release: no toggle.
    bouncy_edge(1'b0, e);
    step(2 * Win);
    check_val("release_db", int'(dut.btn_db_q), 0);
    check_val("release_flag", int'(size_flag), 1);

    // Second press: 1->0.
    bouncy_edge(1'b1, e);
    expect_toggle(e, 0);
    step(2 * Win);
    check_val("press2_flag", int'(size_flag), 0);
    bouncy_edge(1'b0, e);
    step(2 * Win);

    // Press while running is discarded and not replayed.
    run_flag = 1'b1;
    bouncy_edge(1'b1, e);
    step(2 * Win);
    check_val("run_db", int'(dut.btn_db_q), 1);
    check_val("run_flag_hold", int'(size_flag), 0);
    run_flag = 1'b0;
    step(20);
    check_val("run_no_replay", int'(size_flag), 0);
    bouncy_edge(1'b0, e);
    step(2 * Win);

    // Clean press then a one-cycle clear.
    btn = 1'b1;
    expect_toggle(cyc + 1, 1);
    step(2 * Win);
    check_val("press3_flag", int'(size_flag), 1);
    rtg_btn      = 1'b1;
    rtg_e.edge_n = cyc + 1;
    rtg_e.val    = 0;
    sb.push_back(rtg_e);
    step(1);
    rtg_btn = 1'b0;
    check_val("rtg_clear", int'(size_flag), 0);
    btn = 1'b0;
    step(2 * Win);

    // Clear on the same edge as a press commit.
    btn         = 1'b1;
    commit_edge = cyc + 1 + Win - 1 + SyncLat;
    step(commit_edge - cyc - 1);
    rtg_btn = 1'b1;
    step(1);
    rtg_btn = 1'b0;
    check_val("rtg_vs_press_flag", int'(size_flag), 0);
    check_val("rtg_vs_press_db", int'(dut.btn_db_q), 1);
    step(2 * Win);
    check_val("rtg_vs_press_hold", int'(size_flag), 0);
    btn = 1'b0;
    step(2 * Win);

    // Reset mid-count with size_flag set and the button held.
    btn = 1'b1;
    expect_toggle(cyc + 1, 1);
    step(2 * Win);
    btn = 1'b0;
    step(2 * Win);
    btn = 1'b1;
    step(39);
    check_val("pre_rst_cnt_busy", int'(dut.cnt_q != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_flag", int'(size_flag), 0);
    check_val("mid_rst_db", int'(dut.btn_db_q), 0);
    check_val("mid_rst_cnt", int'(dut.cnt_q), 0);
    step(3);
    rst_n = 1'b1;
    expect_toggle(cyc + 1, 1);
    step(Win - 2);
    check_val("post_rst_no_early", int'(size_flag), 0);
    step(2 * Win);
    check_val("post_rst_flag", int'(size_flag), 1);

    step(5);
    check_val("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
